// File: rtl/cnt_ctrl_btn.sv
// rtl/cnt_ctrl_btn.sv - button-to-counter control stage producing ce/up/l/di
// Optional long-press RUN/PAUSE toggle on the direction button: CNT_CTRL_PAUSE_EN
module cnt_ctrl_btn #(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] LOAD_VAL    = WIDTH'(4'b0110),
   parameter int               CLK_HZ      = 27_000_000,
   parameter int               TICK_HZ     = 2,
   parameter int               DB_CYCLES   = 270_000,
   parameter int               LONG_CYCLES = 27_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_dir_n,
   input  logic             btn_load_n,
   output logic             ce,
   output logic             up,
   output logic             l,
   output logic [WIDTH-1:0] di
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam int DBW = $clog2(DB_CYCLES + 1);

   if (DIV < 2 || DB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_cfg
      $error("cnt_ctrl_btn: invalid parameter set");
   end

   typedef enum logic [1:0] {S_RUN, S_LOAD, S_PAUSE} state_t;

   state_t         state_q, state_d, ret_q, ret_d;
   logic [1:0]     sync1, sync2, acc, db_done;
   logic [DBW-1:0] db_cnt [2];
   logic [PW-1:0]  pre_q, pre_d;
   logic           tick, frozen, load_press, load_go, dir_act, long_ev, ce_d;

   assign di = LOAD_VAL;

   // Bit 0 is the direction button, bit 1 the load button; all levels active-low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 2'b11;
         sync2     <= 2'b11;
         acc       <= 2'b11;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1 <= {btn_load_n, btn_dir_n};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == acc[i]) begin
               db_cnt[i] <= '0;
            end else if (db_done[i]) begin
               acc[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   always_comb begin
      db_done = 2'b00;
      for (int i = 0; i < 2; i++) begin
         db_done[i] = (sync2[i] != acc[i]) && (db_cnt[i] == DBW'(DB_CYCLES - 1));
      end
   end

   assign load_press = db_done[1] & ~sync2[1];

`ifdef CNT_CTRL_PAUSE_EN
   localparam int HW = $clog2(LONG_CYCLES + 1);
   logic [HW-1:0] hold;
   logic          long_done;

   // Hold time is measured on the accepted level; a long hold is consumed so its release is inert.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         long_done <= 1'b0;
      end else if (db_done[0] && sync2[0]) begin
         hold      <= '0;
         long_done <= 1'b0;
      end else if (!acc[0] && !long_done) begin
         hold <= hold + HW'(1);
         if (hold == HW'(LONG_CYCLES - 1)) long_done <= 1'b1;
      end
   end

   assign dir_act = db_done[0] & sync2[0] & ~long_done;
   assign long_ev = ~acc[0] & ~long_done & (hold == HW'(LONG_CYCLES - 1));
`else
   assign dir_act = db_done[0] & ~sync2[0];
   assign long_ev = 1'b0;
`endif

   assign tick   = (pre_q == PW'(DIV - 1));
   assign frozen = (state_q == S_PAUSE) || (state_q == S_LOAD && ret_q == S_PAUSE);

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      load_go = 1'b0;
      case (state_q)
         S_RUN: begin
            if (load_press) begin
               load_go = 1'b1;
               state_d = S_LOAD;
               ret_d   = S_RUN;
            end
         end
         S_PAUSE: begin
            if (load_press) begin
               load_go = 1'b1;
               state_d = S_LOAD;
               ret_d   = S_PAUSE;
            end
         end
         S_LOAD:  state_d = ret_q;
         default: state_d = S_RUN;
      endcase
      // A long press landing in LOAD retargets where LOAD returns to.
      if (long_ev) begin
         if (state_d == S_LOAD) ret_d   = (ret_d == S_PAUSE) ? S_RUN : S_PAUSE;
         else                   state_d = (state_d == S_PAUSE) ? S_RUN : S_PAUSE;
      end
      ce_d = tick && (state_q == S_RUN) && !load_go;
      if (load_go)     pre_d = '0;
      else if (frozen) pre_d = pre_q;
      else if (tick)   pre_d = '0;
      else             pre_d = pre_q + PW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         ret_q   <= S_RUN;
         pre_q   <= '0;
         ce      <= 1'b0;
         l       <= 1'b0;
         up      <= 1'b1;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         pre_q   <= pre_d;
         ce      <= ce_d;
         l       <= load_go;
         up      <= up ^ dir_act;
      end
   end
endmodule

// File: tb/tb_cnt_ctrl_btn.sv
// tb/tb_cnt_ctrl_btn.sv - self-checking bench for cnt_ctrl_btn (DIV=4, DB_CYCLES=3, LONG_CYCLES=8)
module tb_cnt_ctrl_btn;
   localparam logic [3:0] LOAD_VAL = 4'b0110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_dir_n = 1'b1;
   logic       btn_load_n = 1'b1;
   logic       ce, up, l;
   logic [3:0] di;
   logic [3:0] q = 4'd0;

   cnt_ctrl_btn #(
      .WIDTH(4), .LOAD_VAL(LOAD_VAL), .CLK_HZ(16), .TICK_HZ(4),
      .DB_CYCLES(3), .LONG_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_dir_n(btn_dir_n), .btn_load_n(btn_load_n),
      .ce(ce), .up(up), .l(l), .di(di)
   );

   always #5 clk = ~clk;

   // Downstream loadable counter fed by the DUT outputs.
   always @(posedge clk) begin
      if (l)       q <= di;
      else if (ce) q <= up ? q + 4'd1 : q - 4'd1;
   end

   typedef struct {int at; logic val;} up_t;

   int   n_checks = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   exp_ce_at = 0;
   int   pause_at = -1;
   int   resume_at = -1;
   int   gap = 0;
   bit   paused = 1'b0;
   bit   q_pending = 1'b0;
   logic exp_up_val = 1'b1;
   logic up_model = 1'b1;
   int   l_q[$];
   up_t  up_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic push_up(input int at);
      up_t e;
      up_model = ~up_model;
      e.at  = at;
      e.val = up_model;
      up_q.push_back(e);
   endtask

   task automatic dir_press();
      btn_dir_n = 1'b0;
`ifndef CNT_CTRL_PAUSE_EN
      push_up(cyc + 5);
`endif
   endtask

   task automatic dir_release();
      btn_dir_n = 1'b1;
`ifdef CNT_CTRL_PAUSE_EN
      push_up(cyc + 5);
`endif
   endtask

   // One clock: sample on the falling edge, pop due expectations, then hand back mid-low-phase.
   task automatic step();
      bit l_exp, ce_exp;
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         chk("rst_ce", ce, 0);
         chk("rst_l", l, 0);
         chk("rst_up", up, 1);
         chk("rst_di", di, LOAD_VAL);
         exp_up_val = 1'b1;
         q_pending  = 1'b0;
      end else begin
         if (q_pending) begin
            chk("cnt_q_after_l", q, LOAD_VAL);
            q_pending = 1'b0;
         end
         l_exp = (l_q.size() > 0) && (l_q[0] == cyc);
         if (l_exp) void'(l_q.pop_front());
         chk("l", l, l_exp);
         if (l_exp) begin
            chk("di_at_l", di, LOAD_VAL);
            if (paused) gap = 4;
            else        exp_ce_at = cyc + 4;
            q_pending = 1'b1;
         end
         if (cyc == resume_at) begin
            paused    = 1'b0;
            exp_ce_at = cyc + gap;
         end
         ce_exp = !paused && (cyc == exp_ce_at);
         chk("ce", ce, ce_exp);
         if (ce_exp) exp_ce_at += 4;
         if (cyc == pause_at) begin
            paused = 1'b1;
            gap    = exp_ce_at - cyc;
         end
         if (up_q.size() > 0 && up_q[0].at == cyc) begin
            exp_up_val = up_q[0].val;
            void'(up_q.pop_front());
         end
         chk("up", up, exp_up_val);
      end
      #2;
   endtask

   initial begin
      // reset, then free-running ticks
      repeat (3) step();
      rst_n = 1'b1;
      exp_ce_at = cyc + 4;
      repeat (16) step();

      // load button held 10 cycles
      btn_load_n = 1'b0;
      l_q.push_back(cyc + 5);
      repeat (10) step();
      btn_load_n = 1'b1;
      repeat (10) step();

      // bouncing direction press, then a clean press
      btn_dir_n = 1'b0;
      repeat (2) step();
      btn_dir_n = 1'b1;
      step();
      dir_press();
      repeat (4) step();
      dir_release();
      repeat (10) step();
      dir_press();
      repeat (5) step();
      dir_release();
      repeat (10) step();

      // load and dir on the same cycle, aligned so l lands on a tick
      for (int i = 0; i < 8 && exp_ce_at != cyc + 1; i++) step();
      btn_load_n = 1'b0;
      l_q.push_back(cyc + 5);
      dir_press();
      repeat (5) step();
      btn_load_n = 1'b1;
      dir_release();
      repeat (10) step();

      // reset asserted during the l cycle
      btn_load_n = 1'b0;
      l_q.push_back(cyc + 5);
      repeat (5) step();
      rst_n = 1'b0;
      btn_load_n = 1'b1;
      #1;
      chk("rst_async_l", l, 0);
      chk("rst_async_ce", ce, 0);
      chk("rst_async_up", up, 1);
      up_model = 1'b1;
      repeat (3) step();
      rst_n = 1'b1;
      exp_ce_at = cyc + 4;
      repeat (12) step();

`ifdef CNT_CTRL_PAUSE_EN
      // long hold pauses, load inside pause, long hold resumes
      btn_dir_n = 1'b0;
      pause_at = cyc + 13;
      repeat (12) step();
      btn_dir_n = 1'b1;
      repeat (12) step();
      btn_load_n = 1'b0;
      l_q.push_back(cyc + 5);
      repeat (6) step();
      btn_load_n = 1'b1;
      repeat (10) step();
      btn_dir_n = 1'b0;
      resume_at = cyc + 13;
      repeat (12) step();
      btn_dir_n = 1'b1;
      repeat (20) step();
`endif

      chk("l_queue_drained", l_q.size(), 0);
      chk("up_queue_drained", up_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
